mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  MEM pipeline stage sitting directly upstream of dataMemory; consumes the EX/MEM register.
//  Turns byte/half/word loads and stores into word accesses on the word-indexed memory.
//  Sub-word stores use a 2-cycle read-modify-write FSM that stalls the pipeline.
//  Load extraction and sign extension happen here. Results are registered into MEM/WB.
// PARAMETERS
//  AW        10   word-index width (1024-word memory); dm_addr = {(32-AW)'b0, ex_addr[AW+1:2]}
//  RW         5   destination register index width
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous, active-high reset
//  ex_valid     in   1   EX/MEM holds a valid instruction
//  ex_mem_read  in   1   load
//  ex_mem_write in   1   store (read and write both set: treated as load)
//  ex_size      in   2   SZ_B / SZ_H / SZ_W (mips_mem_pkg)
//  ex_unsigned  in   1   zero-extend sub-word loads (lbu/lhu)
//  ex_reg_write in   1   instruction writes rd (ALU ops pass through)
//  ex_rd        in   RW  destination register
//  ex_addr      in   32  byte address (ALU result)
//  ex_wdata     in   32  store data (rt), or ALU result for non-memory ops
//  stall        out  1   hold IF/ID/EX and EX/MEM this cycle
//  dm_we        out  1   to dataMemory.writeEnable
//  dm_addr      out  32  to dataMemory.address (word index)
//  dm_wdata     out  32  to dataMemory.dataWrite
//  dm_rdata     in   32  from dataMemory.dataOutput (combinational read)
//  wb_valid     out  1   MEM/WB valid
//  wb_reg_write out  1   MEM/WB register-write enable
//  wb_rd        out  RW  MEM/WB destination
//  wb_data      out  32  load data or passed-through ALU result
//  wb_misalign  out  1   misaligned access flag, valid with wb_valid
// BEHAVIOUR
//  - Reset: every wb_* output is 0. FSM goes to IDLE and merge registers clear. stall=0 and dm_we=0 during the reset cycle.
//  - Byte lanes are little-endian: byte k = word[8k+7:8k]. Half k = word[16k+15:16k].
//  - Misaligned access: SZ_H with addr[0]=1, or SZ_W with addr[1:0]!=0.
//    No memory write occurs. Next edge: wb_valid=1, wb_misalign=1, wb_reg_write=0.
//  - Address bits above AW+1 are ignored, so addresses wrap modulo 4*2^AW bytes.
//  - IDLE, load: dm_addr driven and dm_rdata selected by lane, then sign/zero-extended.
//    Result is registered into wb_data at the next edge (latency 1). No stall.
//  - IDLE, word store: dm_we=1 with dm_wdata=ex_wdata in the same cycle. No stall.
//  - IDLE, non-memory op: wb_data<=ex_wdata and wb_reg_write<=ex_reg_write.
//  - IDLE, aligned sub-word store:
//    stall=1; dm_rdata merged with ex_wdata low byte/half into merge_q; word index saved.
//    wb_valid<=0 (bubble). Next state is RMW_WR.
//  - RMW_WR: dm_we=1, dm_addr=saved index, dm_wdata=merge_q. stall=0.
//    Uses saved copies only; ex_* values are ignored. wb_valid<=1, wb_reg_write<=0. Next state is IDLE.
//    The held store therefore retires exactly once and cannot re-trigger.
//  - ex_valid=0 in IDLE: dm_we=0, wb_valid<=0, no state change.
//  - Back-to-back sub-word stores to the same word:
//    the second store reads after the first store's write edge, so it merges onto the updated word.
//  - Reset asserted in RMW_WR: dm_we is forced to 0 that cycle and the pending write is discarded.
//  - stall depends only on the FSM state and the current ex_* inputs; it never depends on dm_we.
// STRUCTURE
//  - Package mips_mem_pkg holds:
//    SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10; state typedef {IDLE, RMW_WR};
//    functions lane_extract(word, addr[1:0], size, uns) and lane_merge(word, wdata, addr[1:0], size).
//  - One sub-module: mem_lane_unit (combinational extract/merge), shared by the load and RMW paths.
//  - The top level holds the FSM, the saved index/merge registers and the MEM/WB register.
// TESTING
//  1. Write 0x12345678 to byte address 0x40, then load it back as a word.
//     -> one cycle after the load, wb_data=0x12345678, wb_reg_write=1, stall never set.
//  2. Store byte 0xAB to 0x41 over word 0x12345678.
//     -> stall=1 for one cycle, dm_we=1 in the next cycle with dm_addr=0x10 and dm_wdata=0x1234AB78.
//     -> loading 0x41 zero-extended gives 0x000000AB; sign-extended gives 0xFFFFFFAB.
//  3. Store half 0xBEEF to 0x42 over word 0x1234AB78.
//     -> the word becomes 0xBEEFAB78.
//     -> loading 0x42 sign-extended gives 0xFFFFBEEF; zero-extended gives 0x0000BEEF.
//  4. Word load at 0x41, then half store at 0x43.
//     -> each gives wb_misalign=1 and wb_reg_write=0; dm_we stays 0 throughout.
//  5. Byte store to 0x80 then byte store to 0x81, issued back-to-back (word 0x80 initially 0, data 0x11 then 0x22).
//     -> the final word is 0x00002211; total stall cycles = 2.
//  6. Reset raised during the RMW_WR cycle.
//     -> dm_we=0, state returns to IDLE, all wb_* outputs are 0 and stall=0 on the following cycle.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and byte-lane helpers for the MEM stage.
package mips_mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    // Pull a byte/half/word out of a little-endian word and extend it.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [1:0]  size,
                                                 input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    res = uns ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_H:    res = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Overlay the low byte/half of wdata onto the addressed lane of word.
    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size);
        logic [31:0] res;
        res = word;
        case (size)
            SZ_B: begin
                case (off)
                    2'd0:    res[7:0]   = wdata[7:0];
                    2'd1:    res[15:8]  = wdata[7:0];
                    2'd2:    res[23:16] = wdata[7:0];
                    default: res[31:24] = wdata[7:0];
                endcase
            end
            SZ_H: begin
                if (off[1]) res[31:16] = wdata[15:0];
                else        res[15:0]  = wdata[15:0];
            end
            default: res = wdata;
        endcase
        return res;
    endfunction

    // Halves need an even address, words a multiple of four; bytes never fault.
    function automatic logic is_misaligned(input logic [1:0] off,
                                           input logic [1:0] size);
        return ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'd0));
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// EX/MEM inputs, dataMemory port and MEM/WB outputs of the MEM stage.
// Handshake: the stage consumes the EX/MEM entry on a clock edge where
// ex_valid=1 and stall=0; while stall=1 the producer must hold every ex_*
// signal unchanged. wb_valid marks a MEM/WB entry for exactly one cycle.
interface mem_access_stage_if #(
    parameter int AW = 10,
    parameter int RW = 5
);
    logic          ex_valid;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic [1:0]    ex_size;
    logic          ex_unsigned;
    logic          ex_reg_write;
    logic [RW-1:0] ex_rd;
    logic [31:0]   ex_addr;
    logic [31:0]   ex_wdata;
    logic          stall;
    logic          dm_we;
    logic [31:0]   dm_addr;
    logic [31:0]   dm_wdata;
    logic [31:0]   dm_rdata;
    logic          wb_valid;
    logic          wb_reg_write;
    logic [RW-1:0] wb_rd;
    logic [31:0]   wb_data;
    logic          wb_misalign;

    modport slave (
        input  ex_valid, ex_mem_read, ex_mem_write, ex_size, ex_unsigned,
               ex_reg_write, ex_rd, ex_addr, ex_wdata, dm_rdata,
        output stall, dm_we, dm_addr, dm_wdata,
               wb_valid, wb_reg_write, wb_rd, wb_data, wb_misalign
    );

    modport master (
        output ex_valid, ex_mem_read, ex_mem_write, ex_size, ex_unsigned,
               ex_reg_write, ex_rd, ex_addr, ex_wdata, dm_rdata,
        input  stall, dm_we, dm_addr, dm_wdata,
               wb_valid, wb_reg_write, wb_rd, wb_data, wb_misalign
    );

endinterface

// File: rtl/mem_lane_unit.sv
// Combinational lane logic: load extraction and sub-word store merge.
module mem_lane_unit
    import mips_mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_uns,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_data
);

    assign o_load_data  = lane_extract(i_rdata, i_off, i_size, i_uns);
    assign o_merge_data = lane_merge(i_rdata, i_wdata, i_off, i_size);

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: word-indexed memory access with sub-word RMW stores
// and a registered MEM/WB output.
module mem_access_stage
    import mips_mem_pkg::*;
#(
    parameter int AW = 10,
    parameter int RW = 5
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_stage_if.slave bus,
    output state_t            o_dbg_state
);

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_idx;
    logic [31:0]   r_merge;
    logic          r_wb_valid;
    logic          r_wb_reg_write;
    logic [RW-1:0] r_wb_rd;
    logic [31:0]   r_wb_data;
    logic          r_wb_misalign;

    logic [AW-1:0] w_idx;
    logic [1:0]    w_off;
    logic          w_is_load;
    logic          w_is_store;
    logic          w_mis;
    logic          w_sub_store;
    logic          w_stall;
    logic          w_dm_we;
    logic [AW-1:0] w_dm_idx;
    logic [31:0]   w_dm_wdata;
    logic [31:0]   w_load_data;
    logic [31:0]   w_merge_data;
    logic          w_unused_addr;

    // Upper address bits fall outside the memory and simply wrap.
    assign w_unused_addr = ^bus.ex_addr[31:AW+2];

    assign w_idx       = bus.ex_addr[AW+1:2];
    assign w_off       = bus.ex_addr[1:0];
    // A load with the write bit also set is still a load.
    assign w_is_load   = bus.ex_mem_read;
    assign w_is_store  = bus.ex_mem_write & ~bus.ex_mem_read;
    assign w_mis       = (w_is_load | w_is_store) & is_misaligned(w_off, bus.ex_size);
    assign w_sub_store = bus.ex_valid & w_is_store & ~w_mis &
                         ((bus.ex_size == SZ_B) | (bus.ex_size == SZ_H));

    mem_lane_unit u_lane (
        .i_rdata      (bus.dm_rdata),
        .i_wdata      (bus.ex_wdata),
        .i_off        (w_off),
        .i_size       (bus.ex_size),
        .i_uns        (bus.ex_unsigned),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    // Next state and memory-side outputs; reset silences stall and writes.
    always_comb begin
        w_next     = r_state;
        w_stall    = 1'b0;
        w_dm_we    = 1'b0;
        w_dm_idx   = w_idx;
        w_dm_wdata = bus.ex_wdata;
        case (r_state)
            IDLE: begin
                if (w_sub_store) begin
                    w_stall = 1'b1;
                    w_next  = RMW_WR;
                end else if (bus.ex_valid && w_is_store && !w_mis) begin
                    w_dm_we = 1'b1;
                end
            end
            RMW_WR: begin
                w_dm_we    = 1'b1;
                w_dm_idx   = r_idx;
                w_dm_wdata = r_merge;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (rst) begin
            w_dm_we = 1'b0;
            w_stall = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Capture the merged word and its index while the RMW read is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_merge <= '0;
        end else if (r_state == IDLE && w_sub_store) begin
            r_idx   <= w_idx;
            r_merge <= w_merge_data;
        end
    end

    // MEM/WB register: loads, pass-through results, store retirement, faults.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
            r_wb_rd        <= '0;
            r_wb_data      <= '0;
            r_wb_misalign  <= 1'b0;
        end else if (r_state == RMW_WR) begin
            r_wb_valid     <= 1'b1;
            r_wb_reg_write <= 1'b0;
            r_wb_data      <= '0;
            r_wb_misalign  <= 1'b0;
        end else if (!bus.ex_valid || w_sub_store) begin
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
            r_wb_misalign  <= 1'b0;
        end else begin
            r_wb_valid    <= 1'b1;
            r_wb_rd       <= bus.ex_rd;
            r_wb_misalign <= w_mis;
            if (w_mis || w_is_store) begin
                r_wb_reg_write <= 1'b0;
                r_wb_data      <= '0;
            end else if (w_is_load) begin
                r_wb_reg_write <= bus.ex_reg_write;
                r_wb_data      <= w_load_data;
            end else begin
                r_wb_reg_write <= bus.ex_reg_write;
                r_wb_data      <= bus.ex_wdata;
            end
        end
    end

    assign bus.stall        = w_stall;
    assign bus.dm_we        = w_dm_we;
    assign bus.dm_addr      = {{(32-AW){1'b0}}, w_dm_idx};
    assign bus.dm_wdata     = w_dm_wdata;
    assign bus.wb_valid     = r_wb_valid;
    assign bus.wb_reg_write = r_wb_reg_write;
    assign bus.wb_rd        = r_wb_rd;
    assign bus.wb_data      = r_wb_data;
    assign bus.wb_misalign  = r_wb_misalign;
    assign o_dbg_state      = r_state;

endmodule
